vga_pattern_gen: RTL

//  Pixel source that sits directly upstream of the VGA timing controller. It takes the controller's

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_pattern_gen_if.sv | 25 ++
 rtl/vga_debounce.sv | 55 +++++
 rtl/vga_pattern_gen.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, mode encoding and colour table for the VGA test-pattern source.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W      = 10;
  localparam int RGB_W        = 24;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  localparam logic [RGB_W-1:0] WHITE = 24'hFF_FF_FF;
  localparam logic [RGB_W-1:0] BLACK = 24'h00_00_00;

  // Classic colour-bar order, left to right.
  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = 24'hFF_FF_00;
      3'd2:    c = 24'h00_FF_FF;
      3'd3:    c = 24'h00_FF_00;
      3'd4:    c = 24'hFF_00_FF;
      3'd5:    c = 24'hFF_00_00;
      3'd6:    c = 24'h00_00_FF;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel bus between the VGA timing controller (master) and the pattern source (slave).
interface vga_pattern_gen_if;
  import vga_pkg::*;

  // Flow control: no backpressure. pix_en qualifies every input sample and advances the
  // slave pipeline; rgb_valid marks rgb as a visible pixel, two pix_en ticks after its coordinates.
  logic               pix_en;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               active;
  logic               frame_start;
  logic [RGB_W-1:0]   rgb;
  logic               rgb_valid;

  modport master (
    output pix_en, x, y, active, frame_start,
    input  rgb, rgb_valid
  );

  modport slave (
    input  pix_en, x, y, active, frame_start,
    output rgb, rgb_valid
  );

endinterface

// File: rtl/vga_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, 1-clk rising-edge pulse.
module vga_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             rise_q;
  logic             rise_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: button-driven mode/blank control applied on frame boundaries,
// frame counter and a 2-tick pixel pipeline feeding the VGA output.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CHECK_LOG2      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_pattern_gen_if.slave   pix,
  input  logic               btn_mode,
  input  logic               btn_blank,
  output logic [1:0]         mode
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic mode_rise;
  logic blank_rise;

  vga_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_mode),
    .rise_o (mode_rise)
  );

  vga_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_blank (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_blank),
    .rise_o (blank_rise)
  );

  mode_e      mode_q;
  mode_e      mode_d;
  logic       blanked_q;
  logic       blanked_d;
  logic       mode_pend_q;
  logic       mode_pend_d;
  logic       blank_pend_q;
  logic       blank_pend_d;
  logic [7:0] frame_cnt_q;
  logic [7:0] frame_cnt_d;
  logic       fs_tick;

  assign fs_tick = pix.frame_start & pix.pix_en;

  // A press landing in the frame_start clk is kept pending for the following frame.
  always_comb begin
    mode_d       = mode_q;
    blanked_d    = blanked_q;
    frame_cnt_d  = frame_cnt_q;
    mode_pend_d  = mode_pend_q | mode_rise;
    blank_pend_d = blank_pend_q | blank_rise;
    if (fs_tick) begin
      frame_cnt_d  = frame_cnt_q + 8'd1;
      if (mode_pend_q) begin
        mode_d = mode_e'(mode_q + 2'd1);
      end
      if (blank_pend_q) begin
        blanked_d = ~blanked_q;
      end
      mode_pend_d  = mode_rise;
      blank_pend_d = blank_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q       <= MODE_BARS;
      blanked_q    <= 1'b0;
      mode_pend_q  <= 1'b0;
      blank_pend_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      mode_q       <= mode_d;
      blanked_q    <= blanked_d;
      mode_pend_q  <= mode_pend_d;
      blank_pend_q <= blank_pend_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign mode = mode_q;

  logic [COORD_W-1:0] s1_x_q;
  logic [COORD_W-1:0] s1_y_q;
  logic               s1_act_q;
  logic [RGB_W-1:0]   rgb_q;
  logic [RGB_W-1:0]   rgb_d;
  logic               valid_q;
  logic               valid_d;
  logic               vis;
  logic [2:0]         bar_idx;
  logic               check_bit;

  assign vis = s1_act_q
             && (s1_x_q < COORD_W'(H_ACTIVE))
             && (s1_y_q < COORD_W'(V_ACTIVE));

  // Bar index from a chain of boundary compares instead of a divide.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (s1_x_q >= COORD_W'(k * BAR_W)) begin
        bar_idx = 3'(k);
      end
    end
  end

  assign check_bit = s1_x_q[CHECK_LOG2] ^ s1_y_q[CHECK_LOG2];

  always_comb begin
    rgb_d   = BLACK;
    valid_d = 1'b0;
    case (mode_q)
      MODE_BARS:  rgb_d = bar_color(bar_idx);
      MODE_RAMP:  rgb_d = {s1_x_q[9:2], s1_y_q[8:1], frame_cnt_q};
      MODE_CHECK: rgb_d = check_bit ? WHITE : BLACK;
      MODE_SOLID: rgb_d = {frame_cnt_q, ~frame_cnt_q, frame_cnt_q};
      default:    rgb_d = BLACK;
    endcase
    if (vis && !blanked_q) begin
      valid_d = 1'b1;
    end else begin
      rgb_d = BLACK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      s1_act_q <= 1'b0;
      rgb_q    <= '0;
      valid_q  <= 1'b0;
    end else if (pix.pix_en) begin
      s1_x_q   <= pix.x;
      s1_y_q   <= pix.y;
      s1_act_q <= pix.active;
      rgb_q    <= rgb_d;
      valid_q  <= valid_d;
    end
  end

  assign pix.rgb       = rgb_q;
  assign pix.rgb_valid = valid_q;

endmodule
